ram_sp_arb: RTL and testbench
=============================

RAM_SP_ARB -- requirements
Module: ram_sp_arb

Interface
REQ-001 Parameter DATA, default 72: RAM word width.
REQ-002 Parameter ADDR, default 9: RAM address width.
REQ-003 Parameter DEPTH, default 2**ADDR: number of RAM words.
REQ-004 Parameter PIPELINE, default 0: read latency of the attached single-port RAM (0 gives 1 cycle, 1 gives 2 cycles).
REQ-005 Parameter STARVE_MAX, default 4: consecutive denied write cycles before write priority is forced; legal range 1..15.
REQ-006 clk  in  1  sole clock; all logic is on the rising edge.
REQ-007 rstn  in  1  asynchronous, active-low reset.
REQ-008 rd_req  in  1  read request; rd_addr  in  ADDR  read address.
REQ-009 rd_gnt  out  1  read accepted this cycle (combinational).
REQ-010 rd_rvalid  out  1  read data valid; rd_rdata  out  DATA  read data.
REQ-011 wr_req  in  1  write request; wr_addr  in  ADDR, wr_data  in  DATA.
REQ-012 wr_gnt  out  1  write accepted this cycle (combinational).
REQ-013 flush  in  1  single-cycle pulse requesting a full table clear.
REQ-014 init_busy  out  1  clear sweep in progress.
REQ-015 ram_chip_en, ram_write_en  out  1 each; ram_addr  out  ADDR; ram_write_data  out  DATA; ram_read_data  in  DATA: connection to the single-port RAM.

Function
REQ-016 At most one RAM access per cycle: ram_chip_en = rd_gnt | wr_gnt | sweep write; ram_write_en = wr_gnt | sweep write.
REQ-017 RUN state, both requests pending: read wins unless starve_cnt == STARVE_MAX, in which case write wins.
REQ-018 starve_cnt (4 bits) increments each cycle wr_req is denied, saturates at STARVE_MAX, and clears when wr_gnt is asserted or wr_req is low.
REQ-019 A single pending request is granted in the same cycle; a requester holds its request and operands stable until granted.
REQ-020 rd_rvalid is asserted exactly 1+PIPELINE cycles after rd_gnt, via a valid shift register; rd_rdata passes ram_read_data through unmodified.
REQ-021 A read and a write to the same address in consecutive cycles return the data in RAM order; no forwarding is performed.
REQ-022 Addresses wider than DEPTH-1 are not checked; ram_addr is driven with the granted address unmodified.
REQ-023 States: INIT and RUN. In INIT, one zero-write per cycle is issued to sweep_addr 0..DEPTH-1, with rd_gnt=0, wr_gnt=0 and init_busy=1.
REQ-024 INIT transitions to RUN in the cycle after sweep_addr DEPTH-1 is written; init_busy deasserts in the same cycle RUN is entered.
REQ-025 A flush pulse in RUN moves the FSM to INIT on the next cycle with sweep_addr=0; no grant is issued in the cycle flush is sampled.
REQ-026 flush during INIT is ignored; the sweep is not restarted.
REQ-027 Reads granted before INIT entry still complete; rd_rvalid keeps its scheduled timing.

Reset
REQ-028 rstn low: all grants, ram_chip_en, ram_write_en, rd_rvalid and the valid pipeline = 0; starve_cnt = 0; sweep_addr = 0.
REQ-029 With the macro defined, the state resets to INIT and init_busy resets to 1; without it, the state resets to RUN and init_busy resets to 0.
REQ-030 Reset asserted mid-sweep or mid-read aborts the operation; in-flight rd_rvalid pulses are discarded.

Configuration
REQ-031 Macro RAM_SP_ARB_INIT_EN: when defined, the INIT sweep and flush are implemented as specified.
REQ-032 When undefined, there is no INIT state, init_busy is tied to 0, flush is ignored, and the RAM is not cleared after reset.

Verification
REQ-033 The bench covers the following directed scenarios with DEPTH=16, STARVE_MAX=3, PIPELINE=0, macro defined, unless stated otherwise.
REQ-034 Release reset -> 16 consecutive cycles of ram_write_en=1 with ram_addr 0..15 and ram_write_data=0; init_busy falls on cycle 17; no grants during the sweep.
REQ-035 Write 0xAB to addr 5, then read addr 5 -> rd_rvalid=1 one cycle after rd_gnt with rd_rdata=0xAB; with PIPELINE=1 the same read returns two cycles after rd_gnt.
REQ-036 rd_req and wr_req held high continuously -> reads granted for 3 cycles, then one write grant, and the pattern repeats; starve_cnt returns to 0 after each write grant.
REQ-037 flush pulse with a read granted in the same cycle as INIT entry -> that read's rd_rvalid still appears; a 16-cycle sweep follows; a second flush mid-sweep is ignored.
REQ-038 Assert rstn low at sweep_addr=7 and release it -> the sweep restarts at 0; with the macro undefined, grants are available in the first cycle after reset.

Source files
------------

// File: rtl/ram_sp_arb_if.sv
// ram_sp_arb_if: read/write requester bus of the single-port RAM arbiter.
// The master side issues requests and operands; the slave side (the arbiter)
// returns grants and read data.
interface ram_sp_arb_if #(
  parameter int DATA = 72,
  parameter int ADDR = 9
);
  logic            rd_req;
  logic [ADDR-1:0] rd_addr;
  logic            rd_gnt;
  logic            rd_rvalid;
  logic [DATA-1:0] rd_rdata;
  logic            wr_req;
  logic [ADDR-1:0] wr_addr;
  logic [DATA-1:0] wr_data;
  logic            wr_gnt;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_gnt, rd_rvalid, rd_rdata, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_gnt, rd_rvalid, rd_rdata, wr_gnt
  );
endinterface

// File: rtl/ram_sp_arb.sv
// ram_sp_arb: arbitrates one read port and one write port onto a single-port
// RAM, one access per cycle. Reads win ties unless the writer has been denied
// STARVE_MAX cycles in a row. Read data returns 1+PIPELINE cycles after grant.
// Optional feature macro RAM_SP_ARB_INIT_EN: adds an INIT state that zeroes the
// whole RAM after reset and on a flush pulse (init_busy high while sweeping).
module ram_sp_arb #(
  parameter int DATA       = 72,
  parameter int ADDR       = 9,
  parameter int DEPTH      = 2**ADDR,
  parameter int PIPELINE   = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rstn,
  ram_sp_arb_if.slave     bus,
  input  logic            flush,
  output logic            init_busy,
  output logic            ram_chip_en,
  output logic            ram_write_en,
  output logic [ADDR-1:0] ram_addr,
  output logic [DATA-1:0] ram_write_data,
  input  logic [DATA-1:0] ram_read_data
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic            grant_ok;
  logic            sweep_we;
  logic [ADDR-1:0] sweep_addr;
  logic [3:0]      starve_cnt;
  logic            starved;
  logic [PIPELINE:0] vpipe;

`ifdef RAM_SP_ARB_INIT_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t state;

  // Grants only in RUN, and never in the cycle a flush is being taken.
  assign grant_ok = rstn && (state == RUN) && !flush;
  assign sweep_we = rstn && (state == INIT);

  // Sweep/run state machine: zero every word once, then serve requests.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= INIT;
      init_busy  <= 1'b1;
      sweep_addr <= '0;
    end else begin
      case (state)
        INIT: begin
          if (sweep_addr == ADDR'(DEPTH-1)) begin
            state      <= RUN;
            init_busy  <= 1'b0;
            sweep_addr <= '0;
          end else begin
            sweep_addr <= sweep_addr + 1'b1;
          end
        end
        RUN: begin
          if (flush) begin
            state      <= INIT;
            init_busy  <= 1'b1;
            sweep_addr <= '0;
          end
        end
      endcase
    end
  end
`else
  logic unused_cfg;

  assign grant_ok   = rstn;
  assign sweep_we   = 1'b0;
  assign sweep_addr = '0;
  assign init_busy  = 1'b0;
  assign unused_cfg = flush | (DEPTH == 0);
`endif

  assign starved = (starve_cnt == STARVE_LIM);

  // Read wins a tie unless the writer has reached its starvation limit.
  assign bus.rd_gnt = grant_ok & bus.rd_req & ~(bus.wr_req & starved);
  assign bus.wr_gnt = grant_ok & bus.wr_req & (~bus.rd_req | starved);

  assign ram_chip_en    = bus.rd_gnt | bus.wr_gnt | sweep_we;
  assign ram_write_en   = bus.wr_gnt | sweep_we;
  assign ram_addr       = sweep_we ? sweep_addr :
                          (bus.wr_gnt ? bus.wr_addr : bus.rd_addr);
  assign ram_write_data = sweep_we ? '0 : bus.wr_data;

  // Count consecutive denied write cycles, saturating at the limit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (!bus.wr_req || bus.wr_gnt) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Shift each read grant down the pipe so rd_rvalid lines up with RAM data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= bus.rd_gnt;
      for (int i = 1; i <= PIPELINE; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
    end
  end

  assign bus.rd_rvalid = vpipe[PIPELINE];
  assign bus.rd_rdata  = ram_read_data;

endmodule

// File: tb/tb_ram_sp_arb.sv
// tb_ram_sp_arb: directed bench for ram_sp_arb (DEPTH=16, STARVE_MAX=3).
// dut drives a 1-cycle RAM model, dut2 (PIPELINE=1) a 2-cycle RAM model.
// Sweep/flush scenarios are built when RAM_SP_ARB_INIT_EN is defined.
module tb_ram_sp_arb;

  localparam int DATA = 16;
  localparam int ADDR = 4;
`ifdef RAM_SP_ARB_INIT_EN
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  logic            clk;
  logic            rstn;
  logic            flush;
  logic            init_busy, init_busy2;
  logic            ram_chip_en, ram_write_en, ram_chip_en2, ram_write_en2;
  logic [ADDR-1:0] ram_addr, ram_addr2;
  logic [DATA-1:0] ram_write_data, ram_write_data2;
  logic [DATA-1:0] ram_read_data, ram_read_data2, rq2;
  logic [DATA-1:0] mem  [16];
  logic [DATA-1:0] mem2 [16];
  int vectors;
  int miscompares;

  ram_sp_arb_if #(.DATA(DATA), .ADDR(ADDR)) bus ();
  ram_sp_arb_if #(.DATA(DATA), .ADDR(ADDR)) bus2 ();

  ram_sp_arb #(.DATA(DATA), .ADDR(ADDR), .DEPTH(16), .PIPELINE(0), .STARVE_MAX(3)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .flush(flush), .init_busy(init_busy),
    .ram_chip_en(ram_chip_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
  );

  ram_sp_arb #(.DATA(DATA), .ADDR(ADDR), .DEPTH(16), .PIPELINE(1), .STARVE_MAX(3)) dut2 (
    .clk(clk), .rstn(rstn), .bus(bus2), .flush(1'b0), .init_busy(init_busy2),
    .ram_chip_en(ram_chip_en2), .ram_write_en(ram_write_en2), .ram_addr(ram_addr2),
    .ram_write_data(ram_write_data2), .ram_read_data(ram_read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with 1-cycle read latency
  always @(posedge clk) begin
    if (ram_chip_en) begin
      if (ram_write_en) mem[ram_addr] <= ram_write_data;
      else              ram_read_data <= mem[ram_addr];
    end
  end

  // Single-port RAM with 2-cycle read latency
  always @(posedge clk) begin
    if (ram_chip_en2) begin
      if (ram_write_en2) mem2[ram_addr2] <= ram_write_data2;
      else               rq2 <= mem2[ram_addr2];
    end
    ram_read_data2 <= rq2;
  end

  task automatic drive(input logic rr, input logic [ADDR-1:0] ra,
                       input logic wr, input logic [ADDR-1:0] wa, input logic [DATA-1:0] wd);
    bus.rd_req = rr; bus.rd_addr = ra; bus.wr_req = wr; bus.wr_addr = wa; bus.wr_data = wd;
  endtask

  task automatic drive2(input logic rr, input logic [ADDR-1:0] ra,
                        input logic wr, input logic [ADDR-1:0] wa, input logic [DATA-1:0] wd);
    bus2.rd_req = rr; bus2.rd_addr = ra; bus2.wr_req = wr; bus2.wr_addr = wa; bus2.wr_data = wd;
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    flush = 1'b0;
    drive(1, 4'd1, 1, 4'd2, 16'h1234);
    drive2(1, 4'd1, 1, 4'd2, 16'h1234);
    @(negedge clk); #1;
    vectors++; if (bus.rd_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rd_gnt: got %b expected 0", bus.rd_gnt); end
    vectors++; if (bus.wr_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wr_gnt: got %b expected 0", bus.wr_gnt); end
    vectors++; if (ram_chip_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_chip_en: got %b expected 0", ram_chip_en); end
    vectors++; if (ram_write_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_write_en: got %b expected 0", ram_write_en); end
    vectors++; if (bus.rd_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rvalid: got %b expected 0", bus.rd_rvalid); end
    vectors++; if (bus2.rd_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rvalid2: got %b expected 0", bus2.rd_rvalid); end
    vectors++; if (init_busy !== EXP_BUSY_RST) begin miscompares++; $display("[TB] FAIL rst_init_busy: got %b expected %b", init_busy, EXP_BUSY_RST); end
    drive2(0, 4'd0, 0, 4'd0, 16'h0);
  endtask

  task automatic test_init();
    @(negedge clk);
    rstn = 1'b1;
`ifdef RAM_SP_ARB_INIT_EN
    drive(1, 4'd9, 0, 4'd0, 16'h0);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      vectors++; if (ram_write_en !== 1'b1) begin miscompares++; $display("[TB] FAIL sweep_we[%0d]: got %b expected 1", i, ram_write_en); end
      vectors++; if (ram_addr !== 4'(i)) begin miscompares++; $display("[TB] FAIL sweep_addr[%0d]: got %0d expected %0d", i, ram_addr, i); end
      vectors++; if (ram_write_data !== 16'h0) begin miscompares++; $display("[TB] FAIL sweep_data[%0d]: got %h expected 0", i, ram_write_data); end
      vectors++; if (bus.rd_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL sweep_rd_gnt[%0d]: got %b expected 0", i, bus.rd_gnt); end
      vectors++; if (init_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL sweep_busy[%0d]: got %b expected 1", i, init_busy); end
    end
    @(negedge clk); #1;
`else
    drive(1, 4'd9, 0, 4'd0, 16'h0);
    #1;
`endif
    vectors++; if (init_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL run_busy: got %b expected 0", init_busy); end
    vectors++; if (bus.rd_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL run_first_gnt: got %b expected 1", bus.rd_gnt); end
    vectors++; if (ram_write_en !== 1'b0) begin miscompares++; $display("[TB] FAIL run_write_en: got %b expected 0", ram_write_en); end
    @(negedge clk); drive(0, 4'd0, 0, 4'd0, 16'h0); #1;
    vectors++; if (bus.rd_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL run_first_rvalid: got %b expected 1", bus.rd_rvalid); end
`ifdef RAM_SP_ARB_INIT_EN
    vectors++; if (bus.rd_rdata !== 16'h0) begin miscompares++; $display("[TB] FAIL cleared_data: got %h expected 0", bus.rd_rdata); end
`endif
    @(negedge clk); #1;
    vectors++; if (bus.rd_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL run_rvalid_drop: got %b expected 0", bus.rd_rvalid); end
  endtask

  task automatic test_write_read();
    @(negedge clk); drive(0, 4'd0, 1, 4'd5, 16'h00AB); #1;
    vectors++; if (bus.wr_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_gnt: got %b expected 1", bus.wr_gnt); end
    vectors++; if (ram_write_en !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_write_en: got %b expected 1", ram_write_en); end
    vectors++; if (ram_addr !== 4'd5) begin miscompares++; $display("[TB] FAIL wr_addr: got %0d expected 5", ram_addr); end
    vectors++; if (ram_write_data !== 16'h00AB) begin miscompares++; $display("[TB] FAIL wr_data: got %h expected 00ab", ram_write_data); end
    @(negedge clk); drive(1, 4'd5, 0, 4'd0, 16'h0); #1;
    vectors++; if (bus.rd_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_gnt: got %b expected 1", bus.rd_gnt); end
    vectors++; if (ram_chip_en !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_chip_en: got %b expected 1", ram_chip_en); end
    vectors++; if (ram_write_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_write_en: got %b expected 0", ram_write_en); end
    vectors++; if (bus.rd_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_early_rvalid: got %b expected 0", bus.rd_rvalid); end
    @(negedge clk); drive(0, 4'd0, 0, 4'd0, 16'h0); #1;
    vectors++; if (bus.rd_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_rvalid: got %b expected 1", bus.rd_rvalid); end
    vectors++; if (bus.rd_rdata !== 16'h00AB) begin miscompares++; $display("[TB] FAIL rd_rdata: got %h expected 00ab", bus.rd_rdata); end
    @(negedge clk); #1;
    vectors++; if (bus.rd_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_rvalid_drop: got %b expected 0", bus.rd_rvalid); end
  endtask

  task automatic test_pipeline();
    @(negedge clk); drive2(0, 4'd0, 1, 4'd3, 16'h00CD); #1;
    vectors++; if (bus2.wr_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL p1_wr_gnt: got %b expected 1", bus2.wr_gnt); end
    @(negedge clk); drive2(1, 4'd3, 0, 4'd0, 16'h0); #1;
    vectors++; if (bus2.rd_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL p1_rd_gnt: got %b expected 1", bus2.rd_gnt); end
    @(negedge clk); drive2(0, 4'd0, 0, 4'd0, 16'h0); #1;
    vectors++; if (bus2.rd_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL p1_rvalid_early: got %b expected 0", bus2.rd_rvalid); end
    @(negedge clk); #1;
    vectors++; if (bus2.rd_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL p1_rvalid: got %b expected 1", bus2.rd_rvalid); end
    vectors++; if (bus2.rd_rdata !== 16'h00CD) begin miscompares++; $display("[TB] FAIL p1_rdata: got %h expected 00cd", bus2.rd_rdata); end
    @(negedge clk); #1;
    vectors++; if (bus2.rd_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL p1_rvalid_drop: got %b expected 0", bus2.rd_rvalid); end
  endtask

  task automatic test_starvation();
    // Both held: R R R W repeating with STARVE_MAX=3
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive(1, 4'd1, 1, 4'd2, 16'h0011); #1;
      vectors++; if (bus.wr_gnt !== (i % 4 == 3)) begin miscompares++; $display("[TB] FAIL starve_wr_gnt[%0d]: got %b expected %b", i, bus.wr_gnt, (i % 4 == 3)); end
      vectors++; if (bus.rd_gnt !== (i % 4 != 3)) begin miscompares++; $display("[TB] FAIL starve_rd_gnt[%0d]: got %b expected %b", i, bus.rd_gnt, (i % 4 != 3)); end
    end
    @(negedge clk); drive(0, 4'd0, 0, 4'd0, 16'h0);
  endtask

  task automatic test_starve_clear();
    // Dropping wr_req clears the count, so a fresh run of 3 reads is owed
    bit wq [7] = '{1, 1, 0, 1, 1, 1, 1};
    bit eg [7] = '{0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); drive(1, 4'd1, wq[i], 4'd2, 16'h0022); #1;
      vectors++; if (bus.wr_gnt !== eg[i]) begin miscompares++; $display("[TB] FAIL clear_wr_gnt[%0d]: got %b expected %b", i, bus.wr_gnt, eg[i]); end
      vectors++; if (bus.rd_gnt !== !eg[i]) begin miscompares++; $display("[TB] FAIL clear_rd_gnt[%0d]: got %b expected %b", i, bus.rd_gnt, !eg[i]); end
    end
    @(negedge clk); drive(0, 4'd0, 0, 4'd0, 16'h0);
    @(negedge clk);
  endtask

  task automatic test_flush();
    @(negedge clk); drive(1, 4'd5, 0, 4'd0, 16'h0); #1;
    vectors++; if (bus.rd_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL fl_pre_gnt: got %b expected 1", bus.rd_gnt); end
    @(negedge clk); flush = 1'b1; #1;
    vectors++; if (bus.rd_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL fl_rvalid: got %b expected 1", bus.rd_rvalid); end
    vectors++; if (bus.rd_rdata !== 16'h00AB) begin miscompares++; $display("[TB] FAIL fl_rdata: got %h expected 00ab", bus.rd_rdata); end
`ifdef RAM_SP_ARB_INIT_EN
    vectors++; if (bus.rd_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_cycle_gnt: got %b expected 0", bus.rd_gnt); end
    vectors++; if (ram_chip_en !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_cycle_chip_en: got %b expected 0", ram_chip_en); end
    drive(0, 4'd0, 0, 4'd0, 16'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); flush = (i == 4); #1;
      vectors++; if (ram_addr !== 4'(i)) begin miscompares++; $display("[TB] FAIL fl_sweep_addr[%0d]: got %0d expected %0d", i, ram_addr, i); end
      vectors++; if (ram_write_en !== 1'b1) begin miscompares++; $display("[TB] FAIL fl_sweep_we[%0d]: got %b expected 1", i, ram_write_en); end
      vectors++; if (init_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL fl_sweep_busy[%0d]: got %b expected 1", i, init_busy); end
    end
    @(negedge clk); flush = 1'b0; drive(1, 4'd5, 0, 4'd0, 16'h0); #1;
    vectors++; if (init_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_done_busy: got %b expected 0", init_busy); end
    vectors++; if (bus.rd_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL fl_done_gnt: got %b expected 1", bus.rd_gnt); end
    @(negedge clk); drive(0, 4'd0, 0, 4'd0, 16'h0); #1;
    vectors++; if (bus.rd_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL fl_post_rvalid: got %b expected 1", bus.rd_rvalid); end
    vectors++; if (bus.rd_rdata !== 16'h0000) begin miscompares++; $display("[TB] FAIL fl_post_rdata: got %h expected 0000", bus.rd_rdata); end
`else
    vectors++; if (bus.rd_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL fl_ignored_gnt: got %b expected 1", bus.rd_gnt); end
    @(negedge clk); flush = 1'b0; drive(0, 4'd0, 0, 4'd0, 16'h0); #1;
    vectors++; if (init_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_busy: got %b expected 0", init_busy); end
    vectors++; if (ram_write_en !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_no_sweep: got %b expected 0", ram_write_en); end
    vectors++; if (bus.rd_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL fl_post_rvalid: got %b expected 1", bus.rd_rvalid); end
    vectors++; if (bus.rd_rdata !== 16'h00AB) begin miscompares++; $display("[TB] FAIL fl_not_cleared: got %h expected 00ab", bus.rd_rdata); end
`endif
    @(negedge clk);
  endtask

`ifdef RAM_SP_ARB_INIT_EN
  task automatic test_reset_mid_sweep();
    @(negedge clk); flush = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); flush = 1'b0; #1;
      vectors++; if (ram_addr !== 4'(i)) begin miscompares++; $display("[TB] FAIL ms_addr[%0d]: got %0d expected %0d", i, ram_addr, i); end
    end
    rstn = 1'b0; #1;
    vectors++; if (ram_write_en !== 1'b0) begin miscompares++; $display("[TB] FAIL ms_rst_we: got %b expected 0", ram_write_en); end
    vectors++; if (init_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL ms_rst_busy: got %b expected 1", init_busy); end
    @(negedge clk); rstn = 1'b1; #1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      vectors++; if (ram_addr !== 4'(i)) begin miscompares++; $display("[TB] FAIL ms_restart_addr[%0d]: got %0d expected %0d", i, ram_addr, i); end
      vectors++; if (ram_write_en !== 1'b1) begin miscompares++; $display("[TB] FAIL ms_restart_we[%0d]: got %b expected 1", i, ram_write_en); end
    end
    @(negedge clk); #1;
    vectors++; if (init_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ms_done_busy: got %b expected 0", init_busy); end
  endtask
`endif

  task automatic test_reset_mid_read();
    @(negedge clk); drive(1, 4'd5, 0, 4'd0, 16'h0); drive2(1, 4'd3, 0, 4'd0, 16'h0); #1;
    vectors++; if (bus.rd_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL mr_gnt: got %b expected 1", bus.rd_gnt); end
    vectors++; if (bus2.rd_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL mr_gnt2: got %b expected 1", bus2.rd_gnt); end
    @(posedge clk); #1;
    drive(0, 4'd0, 0, 4'd0, 16'h0); drive2(0, 4'd0, 0, 4'd0, 16'h0);
    vectors++; if (bus.rd_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL mr_pre_rvalid: got %b expected 1", bus.rd_rvalid); end
    rstn = 1'b0; #1;
    vectors++; if (bus.rd_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL mr_discard: got %b expected 0", bus.rd_rvalid); end
    @(negedge clk); rstn = 1'b1; #1;
    vectors++; if (bus2.rd_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL mr_discard2a: got %b expected 0", bus2.rd_rvalid); end
    @(negedge clk); #1;
    vectors++; if (bus2.rd_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL mr_discard2b: got %b expected 0", bus2.rd_rvalid); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_init();
    test_write_read();
    test_pipeline();
    test_starvation();
    test_starve_clear();
    test_flush();
`ifdef RAM_SP_ARB_INIT_EN
    test_reset_mid_sweep();
`endif
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule
